wasm_stack_seq: RTL and testbench

Sequencer that owns the operand-stack datapath of the WASM core. It accepts decoded stack operations from the decoder over a valid/ready handshake and checks underflow/overflow against its own depth mirror before anything touches the stack. It starts and waits on the ALU for computed results, then drives the stack's pop-count/push strobes for exactly one commit cycle. It sits between the decoder, the ALU and the operand stack, and raises a sticky trap to the core control on any stack or ALU fault.

---
 rtl/wasm_stack_seq.sv | 169 ++++++++++++++++
 tb/tb_wasm_stack_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wasm_stack_seq.sv
`default_nettype none
// wasm_stack_seq: operand-stack sequencer between decoder, ALU and stack; checks depth, commits strobes, traps on faults.
// Revision 1.0
module wasm_stack_seq #(
  parameter int W          = 32,
  parameter int DEPTH_LOG2 = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [1:0]            op_pop,
  input  logic                  op_push,
  input  logic                  op_src,
  input  logic [W-1:0]          op_imm,
  output logic                  alu_start,
  input  logic                  alu_done,
  input  logic [W-1:0]          alu_result,
  output logic [3:0]            st_pop_num,
  output logic                  st_push,
  output logic [W-1:0]          st_push_data,
  output logic [DEPTH_LOG2:0]   depth,
  output logic                  trap,
  output logic [1:0]            trap_code,
  input  logic                  trap_clr
);

  localparam int DW = DEPTH_LOG2 + 2;
  localparam int AW = DEPTH_LOG2 + 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] DEPTH_MAX    = DW'(2 ** DEPTH_LOG2);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] CODE_NONE      = 2'd0;
  localparam logic [1:0] CODE_UNDERFLOW = 2'd1;
  localparam logic [1:0] CODE_OVERFLOW  = 2'd2;
  localparam logic [1:0] CODE_TIMEOUT   = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ALU_WAIT = 2'd1,
    COMMIT   = 2'd2,
    TRAP     = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      pop_q;
  logic            push_q;
  logic [W-1:0]    data_q;
  logic [CW-1:0]   wait_cnt;
  logic [1:0]      code_q;
  logic [AW-1:0]   depth_q;

  logic            accept;
  logic [DW-1:0]   depth_ext;
  logic [DW-1:0]   depth_after;
  logic            underflow;
  logic            overflow;
  logic            timed_out;

  // Checks use one spare bit so depth + 1 cannot wrap; underflow wraps depth_after but wins priority.
  assign accept      = op_valid && (state == IDLE);
  assign depth_ext   = DW'(depth_q);
  assign underflow   = depth_ext < DW'(op_pop);
  assign depth_after = depth_ext - DW'(op_pop) + DW'(op_push);
  assign overflow    = depth_after > DEPTH_MAX;
  assign timed_out   = (wait_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    op_ready     = 1'b0;
    alu_start    = 1'b0;
    st_pop_num   = 4'd0;
    st_push      = 1'b0;
    st_push_data = '0;
    trap         = 1'b0;
    case (state)
      IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          if (underflow || overflow) begin
            state_nxt = TRAP;
          end else if (op_src) begin
            state_nxt = ALU_WAIT;
          end else begin
            state_nxt = COMMIT;
          end
        end
      end
      ALU_WAIT: begin
        alu_start = (wait_cnt == '0);
        if (alu_done) begin
          state_nxt = COMMIT;
        end else if (timed_out) begin
          state_nxt = TRAP;
        end
      end
      COMMIT: begin
        st_pop_num   = 4'(pop_q);
        st_push      = push_q;
        st_push_data = data_q;
        state_nxt    = IDLE;
      end
      TRAP: begin
        trap = 1'b1;
        if (trap_clr) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_q    <= 2'd0;
      push_q   <= 1'b0;
      data_q   <= '0;
      wait_cnt <= '0;
      code_q   <= CODE_NONE;
      depth_q  <= '0;
    end else begin
      if (accept) begin
        pop_q  <= op_pop;
        push_q <= op_push;
        data_q <= op_imm;
        if (underflow) begin
          code_q <= CODE_UNDERFLOW;
        end else if (overflow) begin
          code_q <= CODE_OVERFLOW;
        end
      end

      if (state == ALU_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
        if (alu_done) begin
          data_q <= alu_result;
        end else if (timed_out) begin
          code_q <= CODE_TIMEOUT;
        end
      end else begin
        wait_cnt <= '0;
      end

      if (state == COMMIT) begin
        depth_q <= depth_q - AW'(pop_q) + AW'(push_q);
      end

      if ((state == TRAP) && trap_clr) begin
        code_q <= CODE_NONE;
      end
    end
  end

  assign depth     = depth_q;
  assign trap_code = code_q;

endmodule
`default_nettype wire

// File: tb/tb_wasm_stack_seq.sv
`default_nettype none
// tb_wasm_stack_seq: directed plus randomized ops; expected stack events go through a scoreboard queue,
// the reference is a plain value stack whose size is the expected depth.
module tb_wasm_stack_seq;

  localparam int W   = 32;
  localparam int DL  = 4;
  localparam int TO  = 64;
  localparam int CAP = 16;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic          op_valid   = 1'b0;
  logic          op_ready;
  logic [1:0]    op_pop     = 2'd0;
  logic          op_push    = 1'b0;
  logic          op_src     = 1'b0;
  logic [W-1:0]  op_imm     = '0;
  logic          alu_start;
  logic          alu_done   = 1'b0;
  logic [W-1:0]  alu_result = '0;
  logic [3:0]    st_pop_num;
  logic          st_push;
  logic [W-1:0]  st_push_data;
  logic [DL:0]   depth;
  logic          trap;
  logic [1:0]    trap_code;
  logic          trap_clr   = 1'b0;

  wasm_stack_seq #(.W(W), .DEPTH_LOG2(DL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_pop(op_pop), .op_push(op_push), .op_src(op_src), .op_imm(op_imm),
    .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
    .st_pop_num(st_pop_num), .st_push(st_push), .st_push_data(st_push_data),
    .depth(depth), .trap(trap), .trap_code(trap_code), .trap_clr(trap_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_trap;
    logic [1:0]   code;
    int           pop;
    bit           push;
    logic [W-1:0] data;
  } ev_t;

  ev_t          exp_q[$];
  logic [W-1:0] stk[$];
  int           n_cmp = 0;
  int           n_err = 0;
  bit           prev_trap = 1'b0;
  ev_t          m_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every visible stack strobe or trap onset must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (st_push || (st_pop_num != 4'd0)) begin
        n_cmp++;
        if (exp_q.size() == 0 || exp_q[0].is_trap) begin
          n_err++;
          $display("FAIL commit_unexpected: got pop=%0d push=%0b data=%0h, no commit expected",
                   st_pop_num, st_push, st_push_data);
        end else begin
          m_e = exp_q.pop_front();
          if (m_e.pop != int'(st_pop_num) || m_e.push != st_push || (m_e.push && m_e.data !== st_push_data)) begin
            n_err++;
            $display("FAIL commit: got pop=%0d push=%0b data=%0h expected pop=%0d push=%0b data=%0h",
                     st_pop_num, st_push, st_push_data, m_e.pop, m_e.push, m_e.data);
          end
        end
      end
      if (trap && !prev_trap) begin
        n_cmp++;
        if (exp_q.size() == 0 || !exp_q[0].is_trap) begin
          n_err++;
          $display("FAIL trap_unexpected: got code %0d, no trap expected", trap_code);
        end else begin
          m_e = exp_q.pop_front();
          if (m_e.code !== trap_code) begin
            n_err++;
            $display("FAIL trap_code: got %0d expected %0d", trap_code, m_e.code);
          end
        end
      end
    end
    prev_trap = trap;
  end

  task automatic clear_trap(input bit probe);
    check("trap_ready_low", op_ready, 0);
    if (probe) begin
      op_valid = 1'b1; op_pop = 2'd0; op_push = 1'b1; op_src = 1'b0;
      repeat (2) begin
        @(posedge clk); #1;
        check("trap_ignores_op", op_ready, 0);
        check("trap_depth_held", depth, stk.size());
      end
      op_valid = 1'b0;
    end
    trap_clr = 1'b1;
    @(posedge clk); #1;
    trap_clr = 1'b0;
    check("clr_ready", op_ready, 1);
    check("clr_trap", trap, 0);
    check("clr_code", trap_code, 0);
    check("clr_depth", depth, stk.size());
  endtask

  // Called at #1 after an edge with the DUT idle; returns the same way. lat < 0: ALU never answers.
  task automatic do_op(input int pop, input bit push, input bit src, input logic [W-1:0] val,
                       input int lat, input bit probe);
    bit  uf;
    bit  ofl;
    int  k;
    ev_t e;
    uf  = stk.size() < pop;
    ofl = !uf && (stk.size() - pop + int'(push) > CAP);
    if (uf || ofl) begin
      e = '{is_trap: 1'b1, code: (uf ? 2'd1 : 2'd2), pop: 0, push: 1'b0, data: '0};
      exp_q.push_back(e);
    end else if (src && lat < 0) begin
      e = '{is_trap: 1'b1, code: 2'd3, pop: 0, push: 1'b0, data: '0};
      exp_q.push_back(e);
    end else if (pop != 0 || push) begin
      e = '{is_trap: 1'b0, code: 2'd0, pop: pop, push: push, data: val};
      exp_q.push_back(e);
    end

    op_valid = 1'b1; op_pop = 2'(pop); op_push = push; op_src = src;
    op_imm   = src ? $urandom : val;
    @(posedge clk); #1;
    op_valid = 1'b0;

    if (uf || ofl) begin
      check("fault_trap", trap, 1);
      check("fault_code", trap_code, uf ? 2'd1 : 2'd2);
      check("fault_no_start", alu_start, 0);
      clear_trap(probe);
      return;
    end
    if (src) begin
      check("alu_start", alu_start, 1);
      if (lat < 0) begin
        for (k = 1; k <= TO + 8; k++) begin
          @(posedge clk); #1;
          if (trap) break;
        end
        check("timeout_cycles", k, TO);
        check("timeout_code", trap_code, 3);
        clear_trap(1'b0);
        return;
      end
      repeat (lat) begin
        @(posedge clk); #1;
      end
      if (lat > 0) check("alu_start_pulse", alu_start, 0);
      alu_done = 1'b1; alu_result = val;
      @(posedge clk); #1;
      alu_done = 1'b0; alu_result = $urandom;
    end
    check("commit_ready_low", op_ready, 0);
    repeat (pop) void'(stk.pop_back());
    if (push) stk.push_back(val);
    @(posedge clk); #1;
    check("ready_after_commit", op_ready, 1);
    check("depth", depth, stk.size());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", op_ready, 1);
    check("rst_depth", depth, 0);
    check("rst_trap", trap, 0);
    check("rst_code", trap_code, 0);
    check("rst_push", st_push, 0);
    check("rst_pop", st_pop_num, 0);
    check("rst_start", alu_start, 0);
    check("rst_data", st_push_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(0, 1, 0, 32'hA, 0, 0);
    do_op(0, 1, 0, 32'hB, 0, 0);
    do_op(0, 1, 0, 32'hC, 0, 0);
    do_op(2, 1, 1, 32'h55, 5, 0);
    do_op(1, 0, 0, 32'h0, 0, 0);
    do_op(2, 0, 0, 32'h0, 0, 1);
    while (stk.size() < CAP) do_op(0, 1, 0, $urandom, 0, 0);
    do_op(0, 1, 0, 32'hDEAD, 0, 0);
    do_op(1, 1, 0, 32'hBEEF, 0, 0);
    do_op(1, 1, 1, 32'h0, -1, 0);
    do_op(0, 0, 0, 32'h0, 0, 0);
    do_op(0, 0, 1, 32'h0, 0, 0);
    do_op(1, 1, 1, 32'h1234, 0, 0);
    do_op(3, 0, 0, 32'h0, 0, 0);

    // Reset while waiting on the ALU: nothing may commit afterwards.
    op_valid = 1'b1; op_pop = 2'd0; op_push = 1'b1; op_src = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    check("rstw_start", alu_start, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rstw_ready", op_ready, 1);
    check("rstw_depth", depth, 0);
    check("rstw_start_low", alu_start, 0);
    check("rstw_trap", trap, 0);
    check("rstw_code", trap_code, 0);
    check("rstw_push", st_push, 0);
    stk.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    alu_done = 1'b1; alu_result = 32'hFACE;
    @(posedge clk); #1;
    alu_done = 1'b0;
    @(posedge clk); #1;
    check("rstw_no_commit_depth", depth, 0);
    check("rstw_no_commit_ready", op_ready, 1);

    for (int i = 0; i < 200; i++) begin
      int p;
      int l;
      p = $urandom_range(0, 3);
      l = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 6));
      do_op(p, ($urandom_range(0, 2) != 0), $urandom_range(0, 1), $urandom, l, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
